// File: rtl/multi_lane_conv3x3.sv
// NCH parallel 3x3 convolution lanes sharing one coefficient set, one control FSM and one
// address sequencer; each lane reads its input image from, and writes its result to, its own SRAM bank.
module multi_lane_conv3x3 #(
  parameter int NCH      = 4,
  parameter int IMG_W    = 16,
  parameter int IMG_H    = 16,
  parameter int AW       = 16,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 256,
  parameter int SHIFT    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fc_valid,
  input  logic [7:0]        i_fc,
  input  logic              i_start,
  input  logic              i_pad_mode,
  input  logic [NCH*8-1:0]  i_working_pixel,
  output logic [NCH*AW-1:0] o_addr,
  output logic [NCH-1:0]    o_en,
  output logic [NCH-1:0]    o_wen,
  output logic [NCH*8-1:0]  o_d,
  output logic [NCH*8-1:0]  o_out_pixel,
  output logic [NCH-1:0]    o_out_valid,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic signed [17:0] H_S      = 18'(IMG_H);
  localparam logic signed [17:0] W_S      = 18'(IMG_W);
  localparam logic [15:0]        LAST_ROW = 16'(IMG_H - 1);
  localparam logic [15:0]        LAST_COL = 16'(IMG_W - 1);

  function automatic logic tap_oob(input logic [15:0] row, input logic [15:0] col,
                                   input logic [3:0] tap);
    logic signed [17:0] r;
    logic signed [17:0] c;
    r = $signed({2'b00, row}) + $signed({16'd0, 2'(tap / 4'd3)}) - 18'sd1;
    c = $signed({2'b00, col}) + $signed({16'd0, 2'(tap % 4'd3)}) - 18'sd1;
    tap_oob = (r < 18'sd0) || (r >= H_S) || (c < 18'sd0) || (c >= W_S);
  endfunction

  // Tap position is clamped into the image, which is exactly the edge-replicate address.
  function automatic logic [31:0] tap_addr(input logic [15:0] row, input logic [15:0] col,
                                           input logic [3:0] tap);
    logic signed [17:0] r;
    logic signed [17:0] c;
    r = $signed({2'b00, row}) + $signed({16'd0, 2'(tap / 4'd3)}) - 18'sd1;
    c = $signed({2'b00, col}) + $signed({16'd0, 2'(tap % 4'd3)}) - 18'sd1;
    r = (r < 18'sd0) ? 18'sd0 : ((r >= H_S) ? (H_S - 18'sd1) : r);
    c = (c < 18'sd0) ? 18'sd0 : ((c >= W_S) ? (W_S - 18'sd1) : c);
    tap_addr = 32'(IN_BASE) + 32'(unsigned'(r)) * 32'(IMG_W) + 32'(unsigned'(c));
  endfunction

  function automatic logic [7:0] sat8(input logic signed [19:0] a);
    logic signed [19:0] s;
    s = a >>> SHIFT;
    if (s < 20'sd0) begin
      sat8 = 8'd0;
    end else if (s > 20'sd255) begin
      sat8 = 8'd255;
    end else begin
      sat8 = 8'(s);
    end
  endfunction

  state_t                  r_state;
  state_t                  w_nxt_state;
  logic signed [7:0]       r_coef [9];
  logic [3:0]              r_cnt;
  logic                    r_coef_ready;
  logic                    r_pad_mode;
  logic [15:0]             r_row;
  logic [15:0]             r_col;
  logic [3:0]              r_phase;
  logic signed [19:0]      r_acc [NCH];
  logic [AW-1:0]           r_addr;
  logic                    r_en;
  logic                    r_wen;
  logic                    r_valid;
  logic [NCH*8-1:0]        r_d;
  logic                    r_busy;
  logic                    r_done;

  logic [15:0]             w_nxt_row;
  logic [15:0]             w_nxt_col;
  logic [3:0]              w_nxt_phase;
  logic                    w_nxt_pad;
  logic [3:0]              w_tap_idx;
  logic                    w_tap_zero;
  logic signed [7:0]       w_coef_cur;
  logic [7:0]              w_pix [NCH];
  logic signed [15:0]      w_prod [NCH];
  logic signed [19:0]      w_acc_nxt [NCH];
  logic [AW-1:0]           w_nxt_addr;
  logic                    w_nxt_en;
  logic                    w_nxt_wen;
  logic                    w_nxt_valid;
  logic [NCH*8-1:0]        w_nxt_d;

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Next state and raster/phase sequencing
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_phase = r_phase;
    w_nxt_row   = r_row;
    w_nxt_col   = r_col;
    w_nxt_pad   = r_pad_mode;
    case (r_state)
      S_IDLE: begin
        if (i_start && r_coef_ready) begin
          w_nxt_state = S_RUN;
          w_nxt_phase = 4'd0;
          w_nxt_row   = 16'd0;
          w_nxt_col   = 16'd0;
          w_nxt_pad   = i_pad_mode;
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_phase == 4'd10) begin
          w_nxt_phase = 4'd0;
          if (r_col == LAST_COL) begin
            w_nxt_col = 16'd0;
            if (r_row == LAST_ROW) begin
              w_nxt_row   = 16'd0;
              w_nxt_state = S_DONE;
            end else begin
              w_nxt_row = r_row + 16'd1;
            end
          end else begin
            w_nxt_col = r_col + 16'd1;
          end
        end else begin
          w_nxt_phase = r_phase + 4'd1;
        end
      end
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Read data arriving now belongs to the tap issued last cycle (phase - 1)
  always_comb begin
    w_tap_idx  = ((r_phase >= 4'd1) && (r_phase <= 4'd9)) ? (r_phase - 4'd1) : 4'd0;
    w_tap_zero = !r_pad_mode && tap_oob(r_row, r_col, w_tap_idx);
    w_coef_cur = r_coef[w_tap_idx];
    for (int k = 0; k < NCH; k++) begin
      w_pix[k]  = w_tap_zero ? 8'd0 : i_working_pixel[8*k +: 8];
      w_prod[k] = $signed({8'd0, w_pix[k]}) * $signed({{8{w_coef_cur[7]}}, w_coef_cur});
      if ((r_state == S_RUN) && (r_phase == 4'd0)) begin
        w_acc_nxt[k] = 20'sd0;
      end else if ((r_state == S_RUN) && (r_phase <= 4'd9)) begin
        w_acc_nxt[k] = r_acc[k] + $signed({{4{w_prod[k][15]}}, w_prod[k]});
      end else begin
        w_acc_nxt[k] = r_acc[k];
      end
    end
  end

  // SRAM command for the coming cycle, so the bank port is driven straight from flops
  always_comb begin
    w_nxt_en    = 1'b0;
    w_nxt_wen   = 1'b0;
    w_nxt_valid = 1'b0;
    w_nxt_addr  = {AW{1'b0}};
    w_nxt_d     = {(NCH*8){1'b0}};
    if ((w_nxt_state == S_RUN) && (w_nxt_phase <= 4'd8)) begin
      if (tap_oob(w_nxt_row, w_nxt_col, w_nxt_phase) && !w_nxt_pad) begin
        w_nxt_en = 1'b0;
      end else begin
        w_nxt_en   = 1'b1;
        w_nxt_addr = AW'(tap_addr(w_nxt_row, w_nxt_col, w_nxt_phase));
      end
    end else if ((w_nxt_state == S_RUN) && (w_nxt_phase == 4'd10)) begin
      w_nxt_en    = 1'b1;
      w_nxt_wen   = 1'b1;
      w_nxt_valid = 1'b1;
      w_nxt_addr  = AW'(32'(OUT_BASE) + 32'(w_nxt_row) * 32'(IMG_W) + 32'(w_nxt_col));
      for (int k = 0; k < NCH; k++) begin
        w_nxt_d[8*k +: 8] = sat8(w_acc_nxt[k]);
      end
    end else begin
      w_nxt_en = 1'b0;
    end
  end

  // Sequencer counters, accumulators and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase    <= 4'd0;
      r_row      <= 16'd0;
      r_col      <= 16'd0;
      r_pad_mode <= 1'b0;
      r_addr     <= {AW{1'b0}};
      r_en       <= 1'b0;
      r_wen      <= 1'b0;
      r_valid    <= 1'b0;
      r_d        <= {(NCH*8){1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        r_acc[k] <= 20'sd0;
      end
    end else begin
      r_phase    <= w_nxt_phase;
      r_row      <= w_nxt_row;
      r_col      <= w_nxt_col;
      r_pad_mode <= w_nxt_pad;
      r_addr     <= w_nxt_addr;
      r_en       <= w_nxt_en;
      r_wen      <= w_nxt_wen;
      r_valid    <= w_nxt_valid;
      r_d        <= w_nxt_d;
      r_busy     <= (w_nxt_state == S_RUN);
      r_done     <= (w_nxt_state == S_DONE);
      for (int k = 0; k < NCH; k++) begin
        r_acc[k] <= w_acc_nxt[k];
      end
    end
  end

  // Coefficient load, accepted only while idle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt        <= 4'd0;
      r_coef_ready <= 1'b0;
      for (int t = 0; t < 9; t++) begin
        r_coef[t] <= 8'sd0;
      end
    end else if ((r_state == S_IDLE) && i_fc_valid) begin
      r_coef[r_cnt] <= $signed(i_fc);
      if (r_cnt == 4'd8) begin
        r_cnt        <= 4'd0;
        r_coef_ready <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_addr      = {NCH{r_addr}};
  assign o_en        = {NCH{r_en}};
  assign o_wen       = {NCH{r_wen}};
  assign o_out_valid = {NCH{r_valid}};
  assign o_d         = r_d;
  assign o_out_pixel = r_d;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_multi_lane_conv3x3.sv
// Self-checking bench for multi_lane_conv3x3: banked SRAM model, behavioural convolution
// reference and scenario tasks covering load, padding, clamping, ignore rules and reset.
`timescale 1ns/1ps
module tb_multi_lane_conv3x3;
  localparam int NCH = 4, W = 16, H = 16, AW = 16;
  localparam int IN_BASE = 0, OUT_BASE = 256, SHIFT = 4, NPIX = W * H;

  logic              clk = 1'b0;
  logic              rst, fc_valid, start, pad_mode;
  logic [7:0]        fc;
  logic [NCH*8-1:0]  rdata;
  logic [NCH*AW-1:0] addr;
  logic [NCH-1:0]    en, wen, out_valid;
  logic [NCH*8-1:0]  d, out_pixel;
  logic              busy, done;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] inmem  [NCH][NPIX];
  logic [7:0] outmem [NCH][NPIX];
  int         stamp  [NCH][NPIX];
  int         run_id = 0;
  int         ref_coef [9];
  int         en_cnt = 0, busy_cnt = 0, mirror_err = 0, stray = 0;
  int         valid_cnt [NCH];
  int         fb_k, fb_i, fb_got, fb_exp;

  multi_lane_conv3x3 #(.NCH(NCH), .IMG_W(W), .IMG_H(H), .AW(AW), .IN_BASE(IN_BASE),
                       .OUT_BASE(OUT_BASE), .SHIFT(SHIFT)) dut (
    .i_clk(clk), .i_rst(rst), .i_fc_valid(fc_valid), .i_fc(fc), .i_start(start),
    .i_pad_mode(pad_mode), .i_working_pixel(rdata), .o_addr(addr), .o_en(en), .o_wen(wen),
    .o_d(d), .o_out_pixel(out_pixel), .o_out_valid(out_valid), .o_busy(busy), .o_done(done));

  always #5 clk = ~clk;

  // Banked SRAM: one-cycle read latency, writes captured with the id of the current run
  always @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      int a;
      a = int'(addr[k*AW +: AW]);
      if (en[k] && wen[k]) begin
        if (a >= OUT_BASE && a < OUT_BASE + NPIX) begin
          outmem[k][a - OUT_BASE] <= d[8*k +: 8];
          stamp[k][a - OUT_BASE]  <= run_id;
        end else stray <= stray + 1;
      end else if (en[k]) begin
        if (a >= IN_BASE && a < IN_BASE + NPIX) rdata[8*k +: 8] <= inmem[k][a - IN_BASE];
        else begin
          rdata[8*k +: 8] <= 8'hEE;
          stray <= stray + 1;
        end
      end
    end
  end

  // Activity counters
  initial for (int k = 0; k < NCH; k++) valid_cnt[k] = 0;
  always @(negedge clk) begin
    if (|en) en_cnt <= en_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    for (int k = 0; k < NCH; k++) begin
      if (out_valid[k]) begin
        valid_cnt[k] <= valid_cnt[k] + 1;
        if (out_pixel[8*k +: 8] !== d[8*k +: 8]) mirror_err <= mirror_err + 1;
      end
    end
  end

  function automatic int clampi(int v, int lim);
    return (v < 0) ? 0 : ((v >= lim) ? lim - 1 : v);
  endfunction

  // Reference: direct 3x3 sum over the stored image with the chosen border rule
  function automatic int model_px(int k, int r, int c, logic pad);
    int acc = 0;
    for (int t = 0; t < 9; t++) begin
      int rr, cc, px;
      rr = r + t / 3 - 1;
      cc = c + t % 3 - 1;
      px = 0;
      if (rr >= 0 && rr < H && cc >= 0 && cc < W) px = int'(inmem[k][rr*W + cc]);
      else if (pad) px = int'(inmem[k][clampi(rr, H)*W + clampi(cc, W)]);
      acc += ref_coef[t] * px;
    end
    acc = acc >>> SHIFT;
    return (acc < 0) ? 0 : ((acc > 255) ? 255 : acc);
  endfunction

  function automatic int img_errs(logic pad);
    int errs = 0;
    for (int k = 0; k < NCH; k++)
      for (int i = 0; i < NPIX; i++) begin
        int e;
        e = model_px(k, i / W, i % W, pad);
        if (outmem[k][i] !== 8'(e) || stamp[k][i] != run_id) begin
          if (errs == 0) begin fb_k = k; fb_i = i; fb_got = int'(outmem[k][i]); fb_exp = e; end
          errs++;
        end
      end
    return errs;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fc_valid = 1'b0; fc = 8'd0; start = 1'b0; pad_mode = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic load_coefs(input int first, input int last);
    for (int t = first; t <= last; t++) begin
      fc_valid = 1'b1; fc = 8'(ref_coef[t]);
      tick(1);
    end
    fc_valid = 1'b0;
  endtask

  task automatic set_coefs(input int kind);
    for (int t = 0; t < 9; t++)
      case (kind)
        0: ref_coef[t] = (t == 4) ? 16 : 0;
        1: ref_coef[t] = 16;
        2: ref_coef[t] = (t == 4) ? -16 : 0;
        3: ref_coef[t] = 127;
        default: ref_coef[t] = int'($urandom_range(0, 255)) - 128;
      endcase
  endtask

  task automatic fill(input int mode, input int val);
    for (int k = 0; k < NCH; k++)
      for (int i = 0; i < NPIX; i++)
        inmem[k][i] = (mode == 0) ? 8'((IN_BASE + i + k) & 255) :
                      (mode == 1) ? 8'(val) : 8'($urandom_range(0, 255));
  endtask

  // Cycle numbering: the cycle in which start is high is cycle 0
  task automatic run_job(input logic pad, input logic inject, output int cyc);
    run_id++;
    pad_mode = pad; start = 1'b1;
    tick(1);
    start = 1'b0; pad_mode = ~pad;
    cyc = 1;
    while (cyc < 4000 && done !== 1'b1) begin
      if (inject && cyc == 100) begin start = 1'b1; fc_valid = 1'b1; fc = 8'h5A; end
      if (inject && cyc == 103) begin start = 1'b0; fc_valid = 1'b0; end
      tick(1);
      cyc++;
    end
    tick(1);
  endtask

  task automatic test_reset();
    int e0;
    rst = 1'b1; #1;
    if ((|{addr, en, wen, d, out_pixel, out_valid, busy, done}) !== 1'b0) begin
      n_bad++; $display("FAIL reset_outputs: got addr=%h en=%b busy=%b done=%b, want all 0", addr, en, busy, done);
    end
    n_cmp++;
    do_reset();
    e0 = en_cnt;
    start = 1'b1; tick(1); start = 1'b0; tick(10);
    if (en_cnt != e0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL start_no_coef: en cycles %0d busy %b, want 0 and 0", en_cnt - e0, busy);
    end
    n_cmp++;
  endtask

  task automatic test_partial_then_identity();
    int e0, b0, cyc, errs;
    int v0 [NCH];
    set_coefs(0);
    load_coefs(0, 7);
    e0 = en_cnt;
    start = 1'b1; tick(1); start = 1'b0; tick(20);
    if (en_cnt != e0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL start_8_coefs: en cycles %0d busy %b, want 0 and 0", en_cnt - e0, busy);
    end
    n_cmp++;
    load_coefs(8, 8);
    fill(0, 0);
    b0 = busy_cnt;
    for (int k = 0; k < NCH; k++) v0[k] = valid_cnt[k];
    run_job(1'b0, 1'b0, cyc);
    if (cyc != 2817) begin n_bad++; $display("FAIL identity_done_cycle: got %0d want 2817", cyc); end
    n_cmp++;
    if (busy_cnt - b0 != 2816) begin n_bad++; $display("FAIL identity_busy_len: got %0d want 2816", busy_cnt - b0); end
    n_cmp++;
    for (int k = 0; k < NCH; k++) begin
      if (valid_cnt[k] - v0[k] != 256) begin
        n_bad++; $display("FAIL identity_valid_lane%0d: got %0d want 256", k, valid_cnt[k] - v0[k]);
      end
      n_cmp++;
    end
    errs = img_errs(1'b0);
    if (errs != 0) begin
      n_bad++; $display("FAIL identity_image: %0d bad, lane %0d idx %0d got %0d want %0d", errs, fb_k, fb_i, fb_got, fb_exp);
    end
    n_cmp++;
  endtask

  task automatic test_const_all16();
    int cyc, errs;
    set_coefs(1); load_coefs(0, 8); fill(1, 10);
    run_job(1'b0, 1'b0, cyc);
    if (outmem[0][0] !== 8'd40 || outmem[1][5] !== 8'd60 || outmem[2][17] !== 8'd90) begin
      n_bad++; $display("FAIL zero_pad_points: got %0d/%0d/%0d want 40/60/90", outmem[0][0], outmem[1][5], outmem[2][17]);
    end
    n_cmp++;
    errs = img_errs(1'b0);
    if (errs != 0) begin
      n_bad++; $display("FAIL zero_pad_image: %0d bad, lane %0d idx %0d got %0d want %0d", errs, fb_k, fb_i, fb_got, fb_exp);
    end
    n_cmp++;
    run_job(1'b1, 1'b0, cyc);
    if (outmem[3][0] !== 8'd90 || outmem[0][255] !== 8'd90) begin
      n_bad++; $display("FAIL replicate_corners: got %0d/%0d want 90/90", outmem[3][0], outmem[0][255]);
    end
    n_cmp++;
    errs = img_errs(1'b1);
    if (errs != 0) begin
      n_bad++; $display("FAIL replicate_image: %0d bad, lane %0d idx %0d got %0d want %0d", errs, fb_k, fb_i, fb_got, fb_exp);
    end
    n_cmp++;
  endtask

  task automatic test_clamp();
    int cyc, errs;
    set_coefs(2); load_coefs(0, 8); fill(1, 50);
    run_job(1'b0, 1'b0, cyc);
    errs = img_errs(1'b0);
    if (errs != 0 || outmem[1][100] !== 8'd0) begin
      n_bad++; $display("FAIL neg_clamp: %0d bad, pixel got %0d want 0", errs, outmem[1][100]);
    end
    n_cmp++;
    set_coefs(3); load_coefs(0, 8); fill(1, 255);
    run_job(1'b0, 1'b0, cyc);
    errs = img_errs(1'b0);
    if (errs != 0 || outmem[3][0] !== 8'd255) begin
      n_bad++; $display("FAIL saturate: %0d bad, corner got %0d want 255", errs, outmem[3][0]);
    end
    n_cmp++;
  endtask

  task automatic test_midrun_ignore();
    int cyc, errs;
    set_coefs(9); load_coefs(0, 8); fill(2, 0);
    run_job(1'b1, 1'b1, cyc);
    if (cyc != 2817) begin n_bad++; $display("FAIL midrun_len: got %0d want 2817", cyc); end
    n_cmp++;
    errs = img_errs(1'b1);
    if (errs != 0) begin
      n_bad++; $display("FAIL midrun_image: %0d bad, lane %0d idx %0d got %0d want %0d", errs, fb_k, fb_i, fb_got, fb_exp);
    end
    n_cmp++;
  endtask

  task automatic test_random();
    int cyc, errs;
    logic pad;
    for (int n = 0; n < 2; n++) begin
      set_coefs(9); load_coefs(0, 8); fill(2, 0);
      pad = 1'($urandom_range(0, 1));
      run_job(pad, 1'b0, cyc);
      errs = img_errs(pad);
      if (errs != 0) begin
        n_bad++; $display("FAIL random%0d_image: %0d bad, lane %0d idx %0d got %0d want %0d", n, errs, fb_k, fb_i, fb_got, fb_exp);
      end
      n_cmp++;
    end
  endtask

  task automatic test_reset_midrun();
    int e0, cyc, errs;
    set_coefs(9); load_coefs(0, 8); fill(2, 0);
    run_id++;
    start = 1'b1; tick(1); start = 1'b0;
    tick(225);
    if (busy !== 1'b1) begin n_bad++; $display("FAIL pre_reset_busy: got %b want 1", busy); end
    n_cmp++;
    rst = 1'b1; #1;
    if ((|{addr, en, wen, d, out_pixel, out_valid, busy, done}) !== 1'b0) begin
      n_bad++; $display("FAIL midrun_reset_outputs: got en=%b wen=%b busy=%b, want all 0", en, wen, busy);
    end
    n_cmp++;
    tick(1); rst = 1'b0; tick(1);
    e0 = en_cnt;
    start = 1'b1; tick(1); start = 1'b0; tick(20);
    if (en_cnt != e0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_start: en cycles %0d busy %b, want 0 and 0", en_cnt - e0, busy);
    end
    n_cmp++;
    load_coefs(0, 8);
    run_job(1'b0, 1'b0, cyc);
    errs = img_errs(1'b0);
    if (errs != 0 || cyc != 2817) begin
      n_bad++; $display("FAIL post_reset_run: %0d bad pixels, cycles %0d want 0 and 2817", errs, cyc);
    end
    n_cmp++;
  endtask

  initial begin
    rst = 1'b1; fc_valid = 1'b0; fc = 8'd0; start = 1'b0; pad_mode = 1'b0;
    test_reset();
    test_partial_then_identity();
    test_const_all16();
    test_clamp();
    test_midrun_ignore();
    test_random();
    test_reset_midrun();
    if (mirror_err != 0 || stray != 0) begin
      n_bad++; $display("FAIL bus_integrity: mirror errors %0d stray accesses %0d, want 0 and 0", mirror_err, stray);
    end
    n_cmp++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_lane_conv3x3.md
Name: multi_lane_conv3x3

Overview:
- Parametrised successor of the fixed four-lane filter array: NCH identical 3x3 convolution lanes, each owning one SRAM bank port.
- All lanes share one coefficient load path, one control FSM and one address sequencer. Lanes differ only in bank data.
- Adds a boundary-padding mode (zero or edge-replicate), output rounding shift with clamping, and busy/done status.
- Sits between the coefficient source and the NCH banked SRAMs. Each bank holds an input image at IN_BASE and receives the result image at OUT_BASE.

Parameters:
- NCH, 4: number of lanes / SRAM banks.
- IMG_W, 16: image width in pixels.
- IMG_H, 16: image height in pixels.
- AW, 16: SRAM address width.
- IN_BASE, 0: word address of input pixel (0,0).
- OUT_BASE, 256: word address of output pixel (0,0).
- SHIFT, 4: arithmetic right shift applied to the accumulator before clamping.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous reset, active-high.
- fc_valid  in  1  coefficient strobe.
- fc  in  8  signed coefficient.
- start  in  1  run request pulse.
- pad_mode  in  1  0 = zero padding, 1 = edge replicate; sampled with start.
- working_pixel  in  NCH*8  SRAM read data; lane k uses bits [8k+7:8k].
- addr  out  NCH*AW  SRAM address per lane.
- en  out  NCH  SRAM access enable, active-high.
- wen  out  NCH  SRAM write enable, active-high (0 = read).
- d  out  NCH*8  SRAM write data.
- out_pixel  out  NCH*8  result pixel, mirrors d during writes.
- out_valid  out  NCH  1-cycle pulse per result written.
- busy  out  1  high while in RUN.
- done  out  1  1-cycle pulse after the final write.

Behaviour:
- Reset (async, any state): FSM to IDLE; coef[0..8] = 0; load count = 0; coef_ready = 0; all outputs 0.
- Coefficient load:
  - Allowed in IDLE only. Each fc_valid cycle writes coef[cnt] (row-major, tap 0 = top-left) and increments cnt; cnt wraps 8 -> 0.
  - coef_ready sets when cnt wraps and stays set until reset. A reload simply overwrites.
  - fc_valid in RUN or DONE is ignored.
- FSM:
  - IDLE: start && coef_ready -> RUN; pad_mode latched; row, col and phase cleared. start without coef_ready is ignored. start in RUN/DONE is ignored.
  - RUN: pixels are processed in raster order (row 0..IMG_H-1, col 0..IMG_W-1), 11 cycles per pixel, phase 0..10.
  - After the last pixel's phase 10 -> DONE. DONE lasts 1 cycle, done = 1, then returns to IDLE.
- Phase detail (all lanes driven identically except data):
  - Phases 0..8 issue tap t = phase at offset (dr, dc) = (t/3 - 1, t%3 - 1).
    - In-bounds tap: en = 1, wen = 0, addr = IN_BASE + r*IMG_W + c.
    - Out-of-bounds, zero mode: en = 0, addr = 0, and the tap's data is forced to 0.
    - Out-of-bounds, replicate mode: r and c are clamped into range and a normal read is issued.
  - SRAM read latency is 1 cycle. Phase p in 1..9 does acc += coef[p-1] * pixel (unsigned 8 x signed 8). acc is cleared at phase 0.
  - Phase 10 write: en = 1, wen = 1, addr = OUT_BASE + row*IMG_W + col, d = out_pixel = clamp(acc >>> SHIFT, 0, 255), out_valid = 1.
- Arithmetic: products are 16-bit signed; acc is 20-bit signed, so no overflow occurs for 9 taps.
- Cycle counts:
  - Start edge -> first read on the next cycle.
  - First write on the 11th RUN cycle.
  - Total RUN length = IMG_W*IMG_H*11 cycles.
- Default outputs: en, wen, out_valid and d are 0 whenever not driven as above; busy = (state == RUN).

Test Plan:
- Identity kernel (coef[4] = 16, others 0), zero mode, bank k filled with pixel = (addr + k)&255 -> output region equals input region in every bank; exactly 256 out_valid pulses per lane; done at cycle 2817 after start.
- All coefficients 16, constant input 10:
  - Zero mode: corner (0,0) = 40, edge (0,5) = 60, interior = 90.
  - Replicate mode: every output = 90.
- coef[4] = -16, input 50 -> all outputs 0 (negative clamp). All coefficients 127, input 255 -> all outputs 255 (saturation).
- start pulsed after loading only 8 coefficients -> stays IDLE, no en activity. After the 9th fc_valid, start -> RUN.
- start and fc_valid pulsed mid-run -> ignored: coefficients unchanged, results unchanged, RUN length unchanged.
- rst asserted during phase 5 of pixel 20 -> all outputs 0 immediately, state IDLE, coef_ready = 0. A subsequent start without reloading coefficients is ignored.
